// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter: default width,
// state encoding and counter width.
package piso_pkg;

   localparam int WIDTH = 4;
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   typedef enum logic {
      ST_IDLE  = IDLE,
      ST_SHIFT = SHIFT
   } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the transmitter shifter; flags the last bit of a frame.
module piso_bit_counter #(
   parameter int WIDTH = piso_pkg::WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     enable,
   output logic [$clog2(WIDTH)-1:0] count,
   output logic                     last
);
   import piso_pkg::*;

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0] count_q, count_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Clear wins over enable so a reload on the last bit restarts at 0.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   assign count = count_q;
   assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter, LSB first, with a one-word holding
// register so consecutive frames run with no idle bit between them.
module piso_tx #(
   parameter int WIDTH = piso_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             busy
);
   import piso_pkg::*;

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             cnt_clear;
   logic             cnt_last;
   logic [CW-1:0]    cnt_value;
   logic             accept;
   logic             shifting;

   assign shifting = (state_q == ST_SHIFT);
   assign in_ready = ~hold_full_q;
   assign accept   = in_valid & in_ready;

   piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (shifting),
      .count  (cnt_value),
      .last   (cnt_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clear = 1'b1;
            if (accept) begin
               shift_d = in_data;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_d = shift_q >> 1;
            if (!cnt_last) begin
               if (accept) begin
                  hold_d      = in_data;
                  hold_full_d = 1'b1;
               end
            end else begin
               // Last bit: held word first, then a direct load, else go idle.
               cnt_clear = 1'b1;
               if (hold_full_q) begin
                  shift_d     = hold_q;
                  hold_full_d = accept;
                  if (accept) begin
                     hold_d = in_data;
                  end
               end else if (accept) begin
                  shift_d = in_data;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign sout       = shifting & shift_q[0];
   assign sout_valid = shifting;
   assign done       = shifting & cnt_last;
   assign busy       = shifting | hold_full_q;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a frame-schedule model predicts every output
// each cycle, and a behavioural SIPO receiver checks the delivered words.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         sout_valid;
    logic         done;
    logic         busy;

    int errors;
    int checks;
    int cyc;

    // Model: each accepted word becomes a frame with a start cycle.
    int           fs[$];
    logic [W-1:0] fw[$];

    logic [W-1:0] rx_q;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver end of the link: shifts in at the MSB toward bit 0.
    always @(posedge clk or negedge rst) begin
        if (!rst) rx_q <= '0;
        else if (sout_valid) rx_q <= {sout, rx_q[W-1:1]};
    end

    function automatic logic model_ready(input int c);
        return (fs.size() == 0) || (fs[fs.size()-1] <= c);
    endfunction

    // Expected {sout_valid, sout, done, busy, in_ready} in cycle c.
    function automatic logic [4:0] model_out(input int c);
        logic v, b, d, r;
        v = 1'b0;
        b = 1'b0;
        d = 1'b0;
        r = model_ready(c);
        foreach (fs[i]) begin
            if (c >= fs[i] && c < fs[i] + W) begin
                v = 1'b1;
                b = fw[i][c - fs[i]];
                d = (c == fs[i] + W - 1);
            end
        end
        return {v, b, d, v | ~r, r};
    endfunction

    // A frame whose last bit was clocked at the end of cycle c-1 is due at the receiver in cycle c.
    function automatic bit rx_due(input int c, output logic [W-1:0] w);
        w = '0;
        foreach (fs[i]) begin
            if (fs[i] + W == c) begin
                w = fw[i];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Drive inputs for the edge ending the current cycle, update the model, advance.
    task automatic cycle(input logic v, input logic [W-1:0] d, output bit acc);
        int s;
        in_valid = v;
        in_data  = d;
        acc = v && model_ready(cyc);
        if (acc) begin
            s = cyc + 1;
            if (fs.size() > 0 && fs[fs.size()-1] + W > s) s = fs[fs.size()-1] + W;
            fs.push_back(s);
            fw.push_back(d);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fs.delete();
        fw.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [4:0]   exp;
        logic [W-1:0] w;
        bit           acc;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {sout_valid, sout, done, busy, in_ready}, 5'b00001);
            end
        end
        rst = 1'b1;
        fs.delete();
        fw.delete();
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL reset_release_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            cycle(i == 0, 4'b1010, acc);
        end
    endtask

    task automatic test_single_word();
        logic [4:0]   exp;
        logic [W-1:0] w;
        bit           acc;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL single_word cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL single_word_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            cycle(i == 0, 4'b1011, acc);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]   exp;
        logic [W-1:0] w;
        logic [W-1:0] d;
        bit           acc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL back_to_back_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            d = (i == 0) ? 4'b0110 : 4'b1001;
            cycle(i < 2, d, acc);
        end
    endtask

    task automatic test_hold_full();
        logic [4:0]   exp;
        logic [W-1:0] w;
        logic [W-1:0] words[4];
        int           idx;
        bit           acc;
        do_reset();
        foreach (words[i]) words[i] = W'($urandom);
        idx = 0;
        for (int i = 0; i < 24; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL hold_full cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL hold_full_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            cycle(idx < 4, words[idx % 4], acc);
            if (acc) idx++;
        end
        checks++;
        if (idx !== 4) begin
            errors++;
            $display("FAIL hold_full_count got=%0d exp=%0d", idx, 4);
        end
    endtask

    task automatic test_last_edge_accept();
        logic [4:0]   exp;
        logic [W-1:0] w;
        logic [W-1:0] d;
        bit           acc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL last_edge cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL last_edge_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            // Second word offered only in cycle 4, the first frame's last bit.
            d = (i == 0) ? 4'b1100 : 4'b0011;
            cycle(i == 0 || i == 4, d, acc);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0]   exp;
        logic [W-1:0] w;
        logic [W-1:0] d;
        bit           acc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL mid_reset_pre cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            d = (i == 0) ? 4'b1111 : 4'b0101;
            cycle(i < 2, d, acc);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({sout_valid, sout, done, busy, in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset_async got=%b exp=%b", {sout_valid, sout, done, busy, in_ready}, 5'b00001);
        end
        @(negedge clk);
        rst = 1'b1;
        fs.delete();
        fw.delete();
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL mid_reset_post cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            cycle(1'b0, 4'b0000, acc);
        end
    endtask

    task automatic test_random();
        logic [4:0]   exp;
        logic [W-1:0] w;
        bit           acc;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            exp = model_out(cyc);
            checks++;
            if ({sout_valid, sout, done, busy, in_ready} !== exp) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {sout_valid, sout, done, busy, in_ready}, exp);
            end
            if (rx_due(cyc, w)) begin
                checks++;
                if (rx_q !== w) begin
                    errors++;
                    $display("FAIL random_rx cyc=%0d got=%b exp=%b", cyc, rx_q, w);
                end
            end
            cycle(i < 190 && ($urandom % 3 != 0), W'($urandom), acc);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        cyc      = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold_full();
        test_last_edge_accept();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
